// File: rtl/store_buffer_pkg.sv
// Shared size codes, FSM state, entry layout and byte-lane mask helper for the store buffer.
package store_buffer_pkg;

  localparam logic [2:0] MC_BYTE = 3'b000;
  localparam logic [2:0] MC_HALF = 3'b001;
  localparam logic [2:0] MC_WORD = 3'b010;
  localparam logic [2:0] MC_BU   = 3'b100;
  localparam logic [2:0] MC_HU   = 3'b101;

  // Entry field widths; the top-level width parameters must not exceed these.
  localparam int unsigned SB_ADDR_W = 32;
  localparam int unsigned SB_DATA_W = 32;

  typedef enum logic {IDLE, WRITE} sb_state_t;

  typedef struct packed {
    logic [SB_ADDR_W-1:0] addr;
    logic [SB_DATA_W-1:0] data;
    logic [2:0]           size;
  } sb_entry_t;

  // Bytes of the 32-bit word touched by an access; misaligned halves align down.
  function automatic logic [3:0] lane_mask(logic [2:0] size, logic [1:0] off);
    unique case (size[1:0])
      2'b00:   return 4'b0001 << off;
      2'b01:   return off[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

endpackage

// File: rtl/store_buffer_lane_extract.sv
// sb_lane_extract: picks a byte or half out of a 32-bit word and sign/zero-extends it.
module sb_lane_extract
  import store_buffer_pkg::*;
(
  input  logic [SB_DATA_W-1:0] word,
  input  logic [1:0]           off,
  input  logic [2:0]           memcontrol,
  output logic [SB_DATA_W-1:0] data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = word[8*off +: 8];
    half_sel = off[1] ? word[31:16] : word[15:0];
    unique case (memcontrol)
      MC_BYTE: data = {{24{byte_sel[7]}}, byte_sel};
      MC_BU:   data = {24'b0, byte_sel};
      MC_HALF: data = {{16{half_sel[15]}}, half_sel};
      MC_HU:   data = {16'b0, half_sel};
      default: data = word;
    endcase
  end

endmodule

// File: rtl/store_buffer.sv
// Store FIFO draining to data_mem with load lookup; define STORE_FWD_EN to forward
// covered loads, otherwise any word-address hit stalls the load.
module store_buffer
  import store_buffer_pkg::*;
#(
  parameter int unsigned ADDRESS_WIDTH = 32,
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned DEPTH         = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     we,
  input  logic                     ld_req,
  input  logic [ADDRESS_WIDTH-1:0] alu_result,
  input  logic [DATA_WIDTH-1:0]    wd,
  input  logic [2:0]               memcontrol,
  output logic                     full,
  output logic                     empty,
  output logic                     fwd_hit,
  output logic [DATA_WIDTH-1:0]    fwd_data,
  output logic                     ld_stall,
  output logic                     mem_we,
  output logic [ADDRESS_WIDTH-1:0] mem_a,
  output logic [DATA_WIDTH-1:0]    mem_wd,
  output logic [2:0]               mem_control,
  input  logic                     mem_ready
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam logic [PtrW:0] DepthC = (PtrW+1)'(DEPTH);

  sb_entry_t       entries_q [DEPTH];
  logic [DEPTH-1:0] valid_q;
  logic [PtrW-1:0] head_q, tail_q;
  logic [PtrW:0]   count_q, count_d;
  logic            full_q, empty_q;
  sb_state_t       state_q, state_d;
  logic            push, pop;

  assign push  = we && !full_q;
  assign pop   = (state_q == WRITE) && mem_ready;
  assign full  = full_q;
  assign empty = empty_q;

  always_comb begin
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      valid_q <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
      state_q <= IDLE;
    end else begin
      if (push) begin
        valid_q[tail_q] <= 1'b1;
        tail_q          <= tail_q + 1'b1;
      end
      if (pop) begin
        valid_q[head_q] <= 1'b0;
        head_q          <= head_q + 1'b1;
      end
      count_q <= count_d;
      full_q  <= (count_d == DepthC);
      empty_q <= (count_d == '0);
      state_q <= state_d;
    end
  end

  // Payload needs no reset: valid_q gates every use.
  always_ff @(posedge clk) begin
    if (push) begin
      entries_q[tail_q].addr <= alu_result;
      entries_q[tail_q].data <= wd;
      entries_q[tail_q].size <= memcontrol;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    state_d = (count_d != '0) ? WRITE : IDLE;
      WRITE:   state_d = (count_d != '0) ? WRITE : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    mem_we      = (state_q == WRITE);
    mem_a       = mem_we ? entries_q[head_q].addr : '0;
    mem_wd      = mem_we ? entries_q[head_q].data : '0;
    mem_control = mem_we ? entries_q[head_q].size : '0;
  end

  // Scan oldest to youngest so the last hit is the youngest store.
  logic            match;
  logic [PtrW-1:0] idx;
`ifdef STORE_FWD_EN
  logic [PtrW-1:0] m_idx;
`endif

  always_comb begin
    match = 1'b0;
    idx   = '0;
`ifdef STORE_FWD_EN
    m_idx = head_q;
`endif
    for (int i = 0; i < DEPTH; i++) begin
      idx = head_q + PtrW'(i);
      if (valid_q[idx] &&
          entries_q[idx].addr[ADDRESS_WIDTH-1:2] == alu_result[ADDRESS_WIDTH-1:2]) begin
        match = 1'b1;
`ifdef STORE_FWD_EN
        m_idx = idx;
`endif
      end
    end
  end

`ifdef STORE_FWD_EN
  sb_entry_t           m;
  logic [3:0]          ld_mask, st_mask;
  logic                covered;
  logic [DATA_WIDTH-1:0] word_view, ext_data;

  always_comb begin
    m       = entries_q[m_idx];
    ld_mask = lane_mask(memcontrol, alu_result[1:0]);
    st_mask = lane_mask(m.size, m.addr[1:0]);
    covered = (ld_mask & ~st_mask) == 4'b0000;
    // Replicate narrow store data across lanes, as data_mem would place it.
    unique case (m.size[1:0])
      2'b00:   word_view = {4{m.data[7:0]}};
      2'b01:   word_view = {2{m.data[15:0]}};
      default: word_view = m.data;
    endcase
  end

  sb_lane_extract u_lane_extract (
    .word       (word_view),
    .off        (alu_result[1:0]),
    .memcontrol (memcontrol),
    .data       (ext_data)
  );

  always_comb begin
    fwd_hit  = ld_req && match && covered;
    ld_stall = ld_req && match && !covered;
    fwd_data = fwd_hit ? ext_data : '0;
  end
`else
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    ld_stall = ld_req && match;
  end
`endif

endmodule

// File: tb/tb_store_buffer.sv
// Directed self-checking bench for store_buffer; expectations follow STORE_FWD_EN.
module tb_store_buffer;

  logic        clk = 1'b0;
  logic        rst, we, ld_req, mem_ready;
  logic [31:0] alu_result, wd;
  logic [2:0]  memcontrol;
  logic        full, empty, fwd_hit, ld_stall, mem_we;
  logic [31:0] fwd_data, mem_a, mem_wd;
  logic [2:0]  mem_control;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  store_buffer dut (
    .clk         (clk),
    .rst         (rst),
    .we          (we),
    .ld_req      (ld_req),
    .alu_result  (alu_result),
    .wd          (wd),
    .memcontrol  (memcontrol),
    .full        (full),
    .empty       (empty),
    .fwd_hit     (fwd_hit),
    .fwd_data    (fwd_data),
    .ld_stall    (ld_stall),
    .mem_we      (mem_we),
    .mem_a       (mem_a),
    .mem_wd      (mem_wd),
    .mem_control (mem_control),
    .mem_ready   (mem_ready)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [2:0] mc);
    we = 1'b1; alu_result = a; wd = d; memcontrol = mc;
    step();
    we = 1'b0;
  endtask

  task automatic load(input logic [31:0] a, input logic [2:0] mc);
    ld_req = 1'b1; alu_result = a; memcontrol = mc;
    #1;
  endtask

  // Expected forward result for a load fully covered by a pending store.
  task automatic chk_fwd(input string tag, input logic [31:0] exp_data);
`ifdef STORE_FWD_EN
    chk({tag, "_hit"}, 32'(fwd_hit), 32'd1);
    chk({tag, "_data"}, fwd_data, exp_data);
    chk({tag, "_stall"}, 32'(ld_stall), 32'd0);
`else
    chk({tag, "_hit"}, 32'(fwd_hit), 32'd0);
    chk({tag, "_data"}, fwd_data, 32'd0 & exp_data);
    chk({tag, "_stall"}, 32'(ld_stall), 32'd1);
`endif
  endtask

  initial begin
    rst = 1'b1; we = 1'b0; ld_req = 1'b0; mem_ready = 1'b0;
    alu_result = '0; wd = '0; memcontrol = '0;
    step(); step();
    rst = 1'b0;
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_mem_a", mem_a, 32'd0);
    chk("rst_mem_wd", mem_wd, 32'd0);
    chk("rst_mem_ctl", 32'(mem_control), 32'd0);
    chk("rst_fwd_hit", 32'(fwd_hit), 32'd0);
    chk("rst_ld_stall", 32'(ld_stall), 32'd0);

    // Single word store drains the next cycle.
    mem_ready = 1'b1;
    store(32'h100, 32'hDEADBEEF, 3'b010);
    chk("sw_mem_we", 32'(mem_we), 32'd1);
    chk("sw_mem_a", mem_a, 32'h100);
    chk("sw_mem_wd", mem_wd, 32'hDEADBEEF);
    chk("sw_mem_ctl", 32'(mem_control), 32'd2);
    chk("sw_empty0", 32'(empty), 32'd0);
    step();
    chk("sw_empty1", 32'(empty), 32'd1);
    chk("sw_idle", 32'(mem_we), 32'd0);

    // Fill, overflow attempt, then back-to-back drain in order.
    mem_ready = 1'b0;
    for (int i = 0; i < 4; i++) store(32'h400 + 32'(4 * i), 32'(i + 1), 3'b010);
    chk("fill_full", 32'(full), 32'd1);
    store(32'h500, 32'h55, 3'b010);
    chk("ovf_full", 32'(full), 32'd1);
    mem_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("drain_we", 32'(mem_we), 32'd1);
      chk("drain_a", mem_a, 32'h400 + 32'(4 * i));
      chk("drain_wd", mem_wd, 32'(i + 1));
      step();
      chk("drain_full", 32'(full), 32'd0);
    end
    chk("drain_idle", 32'(mem_we), 32'd0);
    chk("drain_empty", 32'(empty), 32'd1);

    // Word store forwarded to word load.
    mem_ready = 1'b0;
    store(32'h200, 32'h11223344, 3'b010);
    chk("noreq_hit", 32'(fwd_hit), 32'd0);
    chk("noreq_data", fwd_data, 32'd0);
    load(32'h200, 3'b010);
    chk_fwd("lw", 32'h11223344);
    load(32'h900, 3'b010);
    chk("miss_hit", 32'(fwd_hit), 32'd0);
    chk("miss_stall", 32'(ld_stall), 32'd0);
    ld_req = 1'b0; mem_ready = 1'b1;
    step();
    mem_ready = 1'b0;
    chk("lw_drained", 32'(empty), 32'd1);

    // Sign/zero extension of a byte out of a word store.
    store(32'h200, 32'h000000F0, 3'b010);
    load(32'h200, 3'b000);
    chk_fwd("lb", 32'hFFFFFFF0);
    load(32'h200, 3'b100);
    chk_fwd("lbu", 32'h000000F0);
    load(32'h202, 3'b001);
    chk_fwd("lh_hi", 32'h00000000);
    ld_req = 1'b0; mem_ready = 1'b1;
    step();
    mem_ready = 1'b0;

    // Partial overlap stalls until the byte store pops.
    store(32'h301, 32'h000000AA, 3'b000);
    load(32'h301, 3'b100);
    chk_fwd("lbu_sb", 32'h000000AA);
    load(32'h301, 3'b000);
    chk_fwd("lb_sb", 32'hFFFFFFAA);
    load(32'h300, 3'b010);
    chk("part_stall", 32'(ld_stall), 32'd1);
    chk("part_hit", 32'(fwd_hit), 32'd0);
    mem_ready = 1'b1;
    #1;
    chk("part_stall_wr", 32'(ld_stall), 32'd1);
    step();
    chk("part_clear", 32'(ld_stall), 32'd0);
    ld_req = 1'b0; mem_ready = 1'b0;

    // Youngest of two matching stores wins.
    store(32'h700, 32'h00000001, 3'b010);
    store(32'h700, 32'h00000002, 3'b010);
    load(32'h700, 3'b010);
    chk_fwd("young", 32'h00000002);
    ld_req = 1'b0;

    // Reset with two stores pending drops them.
    chk("pre_rst_we", 32'(mem_we), 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mid_rst_we", 32'(mem_we), 32'd0);
    chk("mid_rst_empty", 32'(empty), 32'd1);
    chk("mid_rst_full", 32'(full), 32'd0);
    mem_ready = 1'b1;
    step(); step();
    chk("post_rst_we", 32'(mem_we), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/store_buffer.md
Name: store_buffer

Overview:
- Write-side counterpart to the cache read path.
- Accepts CPU stores (address, data, memcontrol) into a small FIFO so the CPU does not wait on data memory.
- Drains entries to data_mem one at a time through a ready handshake.
- Lets loads see pending stores: a matching store is forwarded, or the load is stalled.
- Sits between the execute stage (alu_result, wd, memcontrol) and data_mem's write port, in parallel with cache_2w.

Parameters:
- ADDRESS_WIDTH, 32, width of store/load address.
- DATA_WIDTH, 32, width of store data.
- DEPTH, 4, number of buffer entries; must be a power of two, at least 2.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- we  in  1  CPU store request this cycle.
- ld_req  in  1  CPU load lookup this cycle; never asserted together with we.
- alu_result  in  ADDRESS_WIDTH  store or load byte address.
- wd  in  DATA_WIDTH  store data, right-aligned as in data_mem.
- memcontrol  in  3  funct3 size code: 000 byte, 001 half, 010 word; loads also 100/101 unsigned.
- full  out  1  buffer holds DEPTH entries; CPU must stall stores.
- empty  out  1  buffer holds zero entries.
- fwd_hit  out  1  load fully satisfied from the buffer.
- fwd_data  out  DATA_WIDTH  forwarded load data, valid when fwd_hit.
- ld_stall  out  1  load overlaps a pending store that cannot be forwarded.
- mem_we  out  1  write request to data_mem.
- mem_a  out  ADDRESS_WIDTH  write address to data_mem.
- mem_wd  out  DATA_WIDTH  write data to data_mem.
- mem_control  out  3  size code to data_mem.
- mem_ready  in  1  data_mem accepts the write this cycle.

Behaviour:
- Reset:
  - Clears count, head and tail pointers, and all valid bits.
  - FSM goes to IDLE.
  - Outputs: full=0, empty=1, mem_we=0, mem_a=0, mem_wd=0, mem_control=0, fwd_hit=0, ld_stall=0.
  - Reset mid-drain drops the pending write; mem_we is 0 in the following cycle.
- Push:
  - Condition: we && !full. Entry is written at tail and tail increments modulo DEPTH.
  - we while full is ignored; CPU stall is the caller's responsibility.
- Count:
  - Updates +1 on push only, -1 on pop only, unchanged on push and pop in the same cycle.
  - full and empty are registered, derived from next count.
- FSM IDLE:
  - mem_we=0.
  - Goes to WRITE when count is not 0 at the clock edge; first write asserts one cycle after the first push.
- FSM WRITE:
  - mem_we=1, with mem_a, mem_wd and mem_control driven from the head entry. These stay stable until mem_ready.
  - On mem_we && mem_ready: pop head, advance head.
  - Stay in WRITE if count after the pop is not 0, else go to IDLE.
  - Back-to-back writes give one write per cycle when mem_ready is held high.
- Lookup (combinational, ld_req=1):
  - Compares the word address, alu_result[ADDRESS_WIDTH-1:2], against all valid entries.
  - A same-cycle push is not visible.
  - The head entry under write is still searched until popped.
  - The youngest match wins.
- Forwarding, with the youngest match M:
  - Full forward: load is a word (010) and M is a word store, so fwd_hit=1 and fwd_data=M.data.
  - Covered byte or half: the load lies fully inside M's written bytes. fwd_data is the extracted byte or half, sign- or zero-extended per memcontrol, and fwd_hit=1.
  - Any other overlap: ld_stall=1, fwd_hit=0.
  - No match: fwd_hit=0, ld_stall=0, and the load uses the cache / data_mem path.
- Outputs when ld_req=0: fwd_hit=0, ld_stall=0, fwd_data=0.
- Byte lanes:
  - Byte offset is addr[1:0]; half offset is addr[1].
  - Misaligned halves and words are not supported and are treated as aligned down.

Optional Feature:
- Macro: STORE_FWD_EN.
- Defined: forwarding as above.
- Undefined:
  - fwd_hit is tied 0 and fwd_data is tied 0.
  - Any word-address match with ld_req asserts ld_stall until the matching entry has drained.
  - Lane-extraction logic is removed.

Decomposition:
- Package store_buffer_pkg holds:
  - size localparams MC_BYTE=3'b000, MC_HALF=3'b001, MC_WORD=3'b010, MC_BU=3'b100, MC_HU=3'b101;
  - typedef sb_state_t {IDLE, WRITE};
  - typedef sb_entry_t {addr, data, size}.
- One sub-module, sb_lane_extract: combinational byte/half selection plus sign/zero extension, used for the forward path.

Test Plan:
- Reset then sw 0x100=0xDEADBEEF with mem_ready=1: mem_we=1 next cycle with mem_a=0x100, mem_wd=0xDEADBEEF, mem_control=010. empty returns to 1 one cycle after the handshake.
- Push 4 stores with mem_ready=0: full=1 after the 4th. A 5th we is ignored. Raise mem_ready: 4 writes occur in order on 4 consecutive cycles, then IDLE.
- sw 0x200=0x11223344, then lw 0x200 before drain: fwd_hit=1, fwd_data=0x11223344, ld_stall=0.
- sw 0x200=0x000000F0, then lb 0x200: fwd_hit=1, fwd_data=0xFFFFFFF0. Same store then lbu 0x200: fwd_data=0x000000F0.
- sb 0x301=0xAA, then lw 0x300: ld_stall=1, fwd_hit=0. Stall clears one cycle after the entry pops.
- Two stores pending, mem_we high, assert rst for one cycle: next cycle mem_we=0, empty=1, full=0. No further writes issue.
